// File: rtl/digit_bbox_detect.sv
// -----------------------------------------------------------------------------
// digit_bbox_detect
//
// Scans one binarized raster frame, one pixel per clock, and reports the
// bounding box of the foreground digit together with its pixel count. The
// box feeds the recognizer's edge inputs on the following frame.
//
// A frame begins at the start pixel (row 0, col 0) and ends at the end pixel
// (last row, last col). The cycle after the end pixel is sampled, oValid
// pulses and the result registers take the completed frame's values. Edges
// only move when the frame held enough foreground pixels to be trusted.
//
// Parameters:
//   H_ACTIVE  active columns per line (col 0..H_ACTIVE-1)
//   V_ACTIVE  active rows per frame   (row 0..V_ACTIVE-1)
//   MIN_PIX   foreground count at or above which a box is reported as found
//   FG_POL    0: foreground when iBWData == 10'd0; 1: when iBWData == 10'h3FF
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous reset, active low
//   en         scan enable; low abandons the frame in progress
//   iRow       row coordinate of the current pixel
//   iCol       column coordinate of the current pixel
//   iBWData    binarized pixel value
//   oEdge_Row  {bottom, top} row bounds of the last found box
//   oEdge_Col  {right, left} column bounds of the last found box
//   oCount     foreground pixel count of the last completed frame
//   oFound     last completed frame had oCount >= MIN_PIX
//   oValid     one-cycle pulse when the last-frame outputs update
// -----------------------------------------------------------------------------
module digit_bbox_detect #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int MIN_PIX  = 16,
    parameter int FG_POL   = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [9:0]  iRow,
    input  logic [9:0]  iCol,
    input  logic [9:0]  iBWData,
    output logic [19:0] oEdge_Row,
    output logic [19:0] oEdge_Col,
    output logic [18:0] oCount,
    output logic        oFound,
    output logic        oValid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Running bounding box and foreground count of the frame being scanned.
    typedef struct packed {
        logic [9:0]  min_row;
        logic [9:0]  max_row;
        logic [9:0]  min_col;
        logic [9:0]  max_col;
        logic [18:0] cnt;
    } acc_t;

    // Min trackers start at the top of the range so the first hit replaces
    // them; max trackers start at zero for the same reason.
    localparam acc_t ACC_INIT = '{
        min_row: 10'h3FF,
        max_row: 10'd0,
        min_col: 10'h3FF,
        max_col: 10'd0,
        cnt:     19'd0
    };

    localparam logic [9:0]  FG_LEVEL = (FG_POL != 0) ? 10'h3FF : 10'd0;
    localparam logic [9:0]  LAST_ROW = 10'(V_ACTIVE - 1);
    localparam logic [9:0]  LAST_COL = 10'(H_ACTIVE - 1);
    localparam logic [18:0] CNT_MAX  = 19'h7FFFF;
    localparam logic [18:0] MIN_CNT  = 19'(MIN_PIX);

    state_t state;
    state_t state_next;
    acc_t   acc;
    acc_t   acc_next;
    logic   load;
    logic   found_next;

    logic   in_range;
    logic   fg;
    logic   is_start;
    logic   is_end;

    // Coordinates outside the active window (blanking) never count, even if
    // the pixel value happens to match the foreground level.
    assign in_range = (iRow <= LAST_ROW) && (iCol <= LAST_COL);
    assign fg       = (iBWData == FG_LEVEL) && in_range;
    assign is_start = (iRow == 10'd0) && (iCol == 10'd0);
    assign is_end   = (iRow == LAST_ROW) && (iCol == LAST_COL);

    // Folds one pixel into a set of accumulators. The count saturates rather
    // than wrapping so a huge blob can never look small.
    function automatic acc_t accumulate(input acc_t       a,
                                        input logic       hit,
                                        input logic [9:0] row,
                                        input logic [9:0] col);
        acc_t r;
        r = a;
        if (hit) begin
            if (row < r.min_row) r.min_row = row;
            if (row > r.max_row) r.max_row = row;
            if (col < r.min_col) r.min_col = col;
            if (col > r.max_col) r.max_col = col;
            if (r.cnt != CNT_MAX) r.cnt = r.cnt + 19'd1;
        end
        return r;
    endfunction

    // NOTE: every signal written here gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        acc_next   = acc;
        load       = 1'b0;

        unique case (state)
            IDLE: begin
                if (en && is_start) begin
                    acc_next   = accumulate(ACC_INIT, fg, iRow, iCol);
                    state_next = SCAN;
                end
            end

            SCAN: begin
                if (!en) begin
                    state_next = IDLE;
                end else if (is_start) begin
                    // Frame restarted before its end pixel: discard the
                    // partial frame and begin again from this pixel.
                    acc_next = accumulate(ACC_INIT, fg, iRow, iCol);
                end else begin
                    acc_next = accumulate(acc, fg, iRow, iCol);
                    if (is_end) begin
                        // Results are captured on this same edge from the
                        // updated accumulators, so the end pixel is included.
                        load       = 1'b1;
                        state_next = DONE;
                    end
                end
            end

            // oValid is high for this cycle; any start pixel seen now is
            // deliberately ignored and that frame is skipped.
            DONE: state_next = IDLE;

            default: state_next = IDLE;
        endcase
    end

    assign found_next = (acc_next.cnt >= MIN_CNT);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            acc       <= ACC_INIT;
            oEdge_Row <= 20'd0;
            oEdge_Col <= 20'd0;
            oCount    <= 19'd0;
            oFound    <= 1'b0;
            oValid    <= 1'b0;
        end else begin
            state  <= state_next;
            acc    <= acc_next;
            oValid <= load;
            if (load) begin
                oCount <= acc_next.cnt;
                oFound <= found_next;
                // A sparse frame keeps the previous box so the recognizer
                // does not chase noise.
                if (found_next) begin
                    oEdge_Row <= {acc_next.max_row, acc_next.min_row};
                    oEdge_Col <= {acc_next.max_col, acc_next.min_col};
                end
            end
        end
    end

endmodule

// File: tb/tb_digit_bbox_detect.sv
// -----------------------------------------------------------------------------
// tb_digit_bbox_detect
//
// Directed bench for digit_bbox_detect on a reduced 32x24 raster so that many
// complete frames fit in a short run. A second instance with MIN_PIX=2 shares
// the stimulus and covers the low-threshold corner-pixel case.
//
// Scaled scenarios: rectangle rows 5..15 / cols 4..12 (99 pixels), all-white
// frame, corner pixels, 15- and 16-pixel lines at row 10, mid-frame reset,
// en drop, frame restart and an end-pixel-only frame.
// -----------------------------------------------------------------------------
module tb_digit_bbox_detect;

    localparam int H = 32;
    localparam int V = 24;
    localparam logic [9:0] BLACK = 10'd0;
    localparam logic [9:0] WHITE = 10'h3FF;

    logic        clk;
    logic        rst;
    logic        en;
    logic [9:0]  iRow;
    logic [9:0]  iCol;
    logic [9:0]  iBWData;

    logic [19:0] oEdge_Row;
    logic [19:0] oEdge_Col;
    logic [18:0] oCount;
    logic        oFound;
    logic        oValid;

    logic [19:0] e2_row;
    logic [19:0] e2_col;
    logic [18:0] cnt2;
    logic        found2;
    logic        valid2;

    int checks;
    int errors;
    int valid_cnt;
    int vbase;

    digit_bbox_detect #(.H_ACTIVE(H), .V_ACTIVE(V), .MIN_PIX(16), .FG_POL(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .iRow      (iRow),
        .iCol      (iCol),
        .iBWData   (iBWData),
        .oEdge_Row (oEdge_Row),
        .oEdge_Col (oEdge_Col),
        .oCount    (oCount),
        .oFound    (oFound),
        .oValid    (oValid)
    );

    digit_bbox_detect #(.H_ACTIVE(H), .V_ACTIVE(V), .MIN_PIX(2), .FG_POL(0)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .iRow      (iRow),
        .iCol      (iCol),
        .iBWData   (iBWData),
        .oEdge_Row (e2_row),
        .oEdge_Col (e2_col),
        .oCount    (cnt2),
        .oFound    (found2),
        .oValid    (valid2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts oValid high cycles, sampled mid-cycle.
    initial valid_cnt = 0;
    always @(negedge clk) begin
        if (oValid === 1'b1) valid_cnt <= valid_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic fg_at(input int mode, input int r, input int c);
        case (mode)
            0:       return (r >= 5) && (r <= 15) && (c >= 4) && (c <= 12);
            2:       return ((r == 0) && (c == 0)) || ((r == V-1) && (c == H-1));
            3:       return (r == 10) && (c >= 8) && (c <= 22);
            4:       return (r == 10) && (c >= 8) && (c <= 23);
            5:       return (r == V-1) && (c == H-1);
            default: return 1'b0;
        endcase
    endfunction

    // Drives one pixel for one clock; returns #1 after the sampling edge.
    task automatic pixel(input int r, input int c, input logic [9:0] d);
        iRow    = 10'(r);
        iCol    = 10'(c);
        iBWData = d;
        @(posedge clk);
        #1;
    endtask

    // kind: 0 normal, 1 reset at abort_row, 2 en low for one pixel at
    // abort_row, 3 stop just before abort_row (partial frame).
    task automatic run_frame(input int mode, input int kind, input int abort_row);
        logic [9:0] d;
        for (int r = 0; r < V; r++) begin
            if (r > 0) begin
                // Blanking pixels at foreground level, outside the window.
                pixel(r, H + 3, BLACK);
                pixel(V + 2, 5, BLACK);
            end
            for (int c = 0; c < H; c++) begin
                if (c == 0 && r == abort_row) begin
                    if (kind == 3) return;
                    if (kind == 1) begin
                        rst = 1'b0;
                        #1;
                        check("rst_mid_edge_row", oEdge_Row, 0);
                        check("rst_mid_edge_col", oEdge_Col, 0);
                        check("rst_mid_count", oCount, 0);
                        check("rst_mid_found", oFound, 0);
                        check("rst_mid_valid", oValid, 0);
                        @(posedge clk);
                        #1;
                        rst = 1'b1;
                    end
                end
                if (fg_at(mode, r, c)) d = BLACK;
                else if (mode == 0 && r == 4) d = 10'h155;
                else d = WHITE;
                if (kind == 2 && r == abort_row && c == 0) begin
                    en = 1'b0;
                    pixel(r, c, d);
                    en = 1'b1;
                end else begin
                    pixel(r, c, d);
                end
            end
        end
    endtask

    // Called #1 after the end pixel edge.
    task automatic end_frame(input string tag, input logic exp_valid);
        check({tag, "_valid"}, oValid, exp_valid);
        pixel(1023, 1023, WHITE);
        check({tag, "_valid_width"}, oValid, 0);
        check({tag, "_pulses"}, valid_cnt - vbase, exp_valid ? 1 : 0);
    endtask

    task automatic check_result(input string tag, input logic [19:0] er,
                                input logic [19:0] ec, input int n, input logic f);
        check({tag, "_edge_row"}, oEdge_Row, er);
        check({tag, "_edge_col"}, oEdge_Col, ec);
        check({tag, "_count"}, oCount, n);
        check({tag, "_found"}, oFound, f);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b0;
        en      = 1'b1;
        iRow    = 10'h3FF;
        iCol    = 10'h3FF;
        iBWData = WHITE;
        repeat (3) @(posedge clk);
        #1;
        check_result("reset", 20'd0, 20'd0, 0, 1'b0);
        check("reset_valid", oValid, 0);
        rst = 1'b1;
        pixel(1023, 1023, WHITE);
        check("post_reset_valid", oValid, 0);

        // Rectangle frame.
        vbase = valid_cnt;
        run_frame(0, 0, -1);
        end_frame("rect", 1'b1);
        check_result("rect", {10'd15, 10'd5}, {10'd12, 10'd4}, 99, 1'b1);

        // All-white frame: zero count, edges held.
        vbase = valid_cnt;
        run_frame(1, 0, -1);
        end_frame("white", 1'b1);
        check_result("white", {10'd15, 10'd5}, {10'd12, 10'd4}, 0, 1'b0);

        // Corner pixels: below threshold here, found on the MIN_PIX=2 copy.
        vbase = valid_cnt;
        run_frame(2, 0, -1);
        end_frame("corner", 1'b1);
        check_result("corner", {10'd15, 10'd5}, {10'd12, 10'd4}, 2, 1'b0);
        check("corner2_edge_row", e2_row, {10'd23, 10'd0});
        check("corner2_edge_col", e2_col, {10'd31, 10'd0});
        check("corner2_count", cnt2, 2);
        check("corner2_found", found2, 1);

        // One pixel short of the threshold.
        vbase = valid_cnt;
        run_frame(3, 0, -1);
        end_frame("px15", 1'b1);
        check_result("px15", {10'd15, 10'd5}, {10'd12, 10'd4}, 15, 1'b0);

        // Exactly at the threshold.
        vbase = valid_cnt;
        run_frame(4, 0, -1);
        end_frame("px16", 1'b1);
        check_result("px16", {10'd10, 10'd10}, {10'd23, 10'd8}, 16, 1'b1);

        // Reset mid-frame, then a clean rectangle frame.
        vbase = valid_cnt;
        run_frame(0, 1, 12);
        end_frame("rst_frame", 1'b0);
        check_result("rst_frame", 20'd0, 20'd0, 0, 1'b0);
        vbase = valid_cnt;
        run_frame(0, 0, -1);
        end_frame("rect_again", 1'b1);
        check_result("rect_again", {10'd15, 10'd5}, {10'd12, 10'd4}, 99, 1'b1);

        // en dropped for one pixel: frame abandoned, outputs hold.
        vbase = valid_cnt;
        run_frame(4, 2, 9);
        end_frame("en_drop", 1'b0);
        check_result("en_drop", {10'd15, 10'd5}, {10'd12, 10'd4}, 99, 1'b1);
        vbase = valid_cnt;
        run_frame(4, 0, -1);
        end_frame("after_en", 1'b1);
        check_result("after_en", {10'd10, 10'd10}, {10'd23, 10'd8}, 16, 1'b1);

        // Restart: partial rectangle frame, then a full 15-pixel frame.
        vbase = valid_cnt;
        run_frame(0, 3, 8);
        run_frame(3, 0, -1);
        end_frame("restart", 1'b1);
        check_result("restart", {10'd10, 10'd10}, {10'd23, 10'd8}, 15, 1'b0);

        // End pixel is the only foreground pixel.
        vbase = valid_cnt;
        run_frame(5, 0, -1);
        end_frame("end_only", 1'b1);
        check_result("end_only", {10'd10, 10'd10}, {10'd23, 10'd8}, 1, 1'b0);
        check("end_only2_count", cnt2, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/digit_bbox_detect.md
# digit_bbox_detect

Scans one binarized 640x480 raster frame and reports the bounding box (top/bottom rows, left/right columns) of the foreground digit. It sits between the raster pixel source and `digital_recognition`, and produces the `iEdge_Row`/`iEdge_Col` bounds that the recognizer consumes on the following frame. Results are registered once per frame, with a one-cycle valid pulse and a found flag.

## Interface
- H_ACTIVE, 640, active columns per line; col range 0..H_ACTIVE-1
- V_ACTIVE, 480, active rows per frame; row range 0..V_ACTIVE-1
- MIN_PIX, 16, minimum foreground pixel count for a box to be reported as found
- FG_POL, 0, foreground level: 0 means pixel is foreground when iBWData==10'd0; 1 means foreground when iBWData==10'h3FF
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- en  in  1  scan enable; low aborts the current frame
- iRow  in  10  row coordinate of the current pixel
- iCol  in  10  column coordinate of the current pixel
- iBWData  in  10  binarized pixel, 10'd0 or 10'h3FF; other values are never foreground
- oEdge_Row  out  20  {bottom[19:10], top[9:0]}
- oEdge_Col  out  20  {right[19:10], left[9:0]}
- oCount  out  19  foreground pixel count of the last completed frame
- oFound  out  1  last completed frame had oCount >= MIN_PIX
- oValid  out  1  one-cycle pulse when the last-frame outputs update

## Operation
- iRow, iCol and iBWData are sampled together on each rising clk and describe the same pixel.
- fg = (iBWData == (FG_POL ? 10'h3FF : 10'd0)) && iRow < V_ACTIVE && iCol < H_ACTIVE.
- Out-of-range coordinates are ignored and never update the accumulators.
- Accumulators:
  - min_row / min_col initialise to 10'h3FF.
  - max_row / max_col initialise to 0.
  - cnt initialises to 0.
- On each fg pixel in SCAN:
  - min_row = min(min_row, iRow); max_row = max(max_row, iRow).
  - Same update for the column accumulators using iCol.
  - cnt increments and saturates at 19'h7FFFF.
- States:
  - IDLE: wait for the start pixel (iRow==0 && iCol==0 && en). The start pixel itself is processed with freshly initialised accumulators, and the state moves to SCAN.
  - SCAN: accumulate.
    - On the end pixel (iRow==V_ACTIVE-1 && iCol==H_ACTIVE-1), process that pixel and move to DONE.
    - On a new start pixel before the end pixel (frame restart), reinitialise the accumulators, process the start pixel, and stay in SCAN. No oValid is produced.
  - DONE: one cycle. Pulse oValid, load oCount = cnt and oFound = (cnt >= MIN_PIX).
    - If found: load oEdge_Row = {max_row, min_row} and oEdge_Col = {max_col, min_col}.
    - If not found: oEdge_Row and oEdge_Col keep their previous values.
    - Then go to IDLE. A start pixel arriving during DONE is not captured; that frame is skipped.
- en low in any state: next state is IDLE, the frame is abandoned, no oValid, and all outputs hold. en has no effect on the asynchronous reset path.
- A frame with zero fg pixels gives oCount=0, oFound=0 and previous edges held.

## Timing
- Reset values:
  - oEdge_Row=0, oEdge_Col=0, oCount=0, oFound=0, oValid=0.
  - State IDLE; accumulators at their initial values.
- Latency: oValid is high during the clock cycle immediately after the end pixel is sampled. oEdge_*, oCount and oFound change on that same edge and are stable until the next oValid.
- oValid is exactly one cycle wide, and there is at most one pulse per frame.
- Throughput: one pixel per clock, no stalls, no backpressure.
- Reset asserted mid-frame clears everything immediately. The partial frame yields no result, and the block resynchronises on the next start pixel.
- When the end pixel is also the first fg pixel, it is still counted and included in the box.

## Test plan
- Full 640x480 frame (defaults) with a black rectangle at rows 77..232, cols 74..159 on white -> oValid pulse 1 cycle after pixel (479,639). Outputs: oEdge_Row={10'd232,10'd77}, oEdge_Col={10'd159,10'd74}, oCount=13416, oFound=1.
- Next frame all white -> oValid pulse, oCount=0, oFound=0, oEdge_Row/oEdge_Col still {232,77}/{159,74}.
- Only the corner pixels (0,0) and (479,639) black, with MIN_PIX=2 -> oEdge_Row={479,0}, oEdge_Col={639,0}, oCount=2, oFound=1.
- 15 black pixels at row 100, cols 200..214 (MIN_PIX=16) -> oCount=15, oFound=0, edges unchanged. Repeat with 16 pixels (cols 200..215) -> oFound=1, oEdge_Row={100,100}, oEdge_Col={215,200}.
- Assert rst low at row 300 of a frame containing the rectangle from the first scenario -> all outputs 0 immediately, no oValid for that frame. The next full frame yields the first scenario's result.
- Drop en for one cycle at row 150 -> no oValid that frame. The following frame reports normally.
